// File: rtl/i2c_register_bank.sv
// rtl/i2c_register_bank.sv - pointer-addressed 8-bit register bank behind an I2C slave strobe interface
// Optional receive-byte counter at pointer 8'hFF: define I2C_REGBANK_RXCNT_EN.
module i2c_register_bank #(
    parameter int           NUM_REGS  = 8,
    parameter int           NUM_RW    = 4,
    parameter logic [7:0]   RESET_VAL = 8'h00,
    parameter logic [7:0]   FILL_VAL  = 8'hFF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         i2c_addr_rw,
    input  logic                               i2c_addr_rw_valid_stb,
    input  logic [7:0]                         i2c_data_rx,
    input  logic                               i2c_data_rx_valid_stb,
    output logic [7:0]                         i2c_data_tx,
    input  logic                               i2c_data_tx_loaded_stb,
    input  logic                               i2c_error_stb,
    input  logic [8*(NUM_REGS-NUM_RW)-1:0]     ro_in,
    output logic [8*NUM_RW-1:0]                reg_out,
    output logic                               reg_wr_stb,
    output logic [7:0]                         reg_wr_idx,
    output logic [1:0]                         debug_state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WPTR  = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] READ  = 2'd3;

    localparam int         RO_N     = NUM_REGS - NUM_RW;
    localparam int         RW_A     = (NUM_RW > 0) ? NUM_RW : 1;
    localparam int         RO_A     = (RO_N > 0) ? RO_N : 1;
    localparam logic [7:0] NUM_RW8  = 8'(NUM_RW);
    localparam logic [7:0] LAST8    = 8'(NUM_REGS - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rw_q [RW_A];
    logic [7:0] snap_q [RO_A];
    logic       wr_stb_q;
    logic [7:0] wr_idx_q;
    logic       snap_cap, wr_en, wdata_rx, advance;
    logic       unused_addr;

    assign unused_addr = ^i2c_addr_rw[7:1];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        snap_cap = 1'b0;
        wdata_rx = 1'b0;
        advance  = 1'b0;
        if (i2c_error_stb) begin
            state_d = IDLE;
        end else if (i2c_addr_rw_valid_stb) begin
            state_d  = i2c_addr_rw[0] ? READ : WPTR;
            snap_cap = i2c_addr_rw[0];
        end else begin
            case (state_q)
                WPTR: if (i2c_data_rx_valid_stb) begin
                    ptr_d   = i2c_data_rx;
                    state_d = WDATA;
                end
                WDATA: if (i2c_data_rx_valid_stb) begin
                    wdata_rx = 1'b1;
                    advance  = 1'b1;
                end
                READ:    advance = i2c_data_tx_loaded_stb;
                default: ;
            endcase
        end
        // unmapped pointers stay put so repeated reads keep returning FILL_VAL
        if (advance) begin
            if (ptr_q == LAST8)
                ptr_d = 8'd0;
            else if (ptr_q < LAST8)
                ptr_d = ptr_q + 8'd1;
        end
    end

    assign wr_en = wdata_rx && (ptr_q < NUM_RW8);

`ifdef I2C_REGBANK_RXCNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 8'd0;
        else if (wdata_rx && ptr_q == 8'hFF)
            cnt_q <= 8'd0;
        else if (wdata_rx && cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
    end
`endif

    always_comb begin
        tx_d = FILL_VAL;
        for (int k = 0; k < NUM_RW; k++)
            if (ptr_q == 8'(k)) tx_d = rw_q[k];
        for (int k = 0; k < RO_N; k++)
            if (ptr_q == 8'(NUM_RW + k)) tx_d = snap_q[k];
`ifdef I2C_REGBANK_RXCNT_EN
        if (ptr_q == 8'hFF) tx_d = cnt_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 8'd0;
            tx_q     <= 8'd0;
            wr_stb_q <= 1'b0;
            wr_idx_q <= 8'd0;
            for (int k = 0; k < RW_A; k++) rw_q[k] <= RESET_VAL;
            for (int k = 0; k < RO_A; k++) snap_q[k] <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            tx_q     <= tx_d;
            wr_stb_q <= wr_en;
            if (wr_en) wr_idx_q <= ptr_q;
            for (int k = 0; k < NUM_RW; k++)
                if (wr_en && ptr_q == 8'(k)) rw_q[k] <= i2c_data_rx;
            if (snap_cap)
                for (int k = 0; k < RO_N; k++) snap_q[k] <= ro_in[8*k +: 8];
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
        assign reg_out[8*g +: 8] = rw_q[g];
    end

    assign i2c_data_tx = tx_q;
    assign reg_wr_stb  = wr_stb_q;
    assign reg_wr_idx  = wr_idx_q;
    assign debug_state = state_q;
endmodule

// File: tb/tb_i2c_register_bank.sv
// tb/tb_i2c_register_bank.sv - directed-vector bench for i2c_register_bank
module tb_i2c_register_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr_rw = 8'h00;
    logic        addr_stb = 1'b0;
    logic [7:0]  data_rx = 8'h00;
    logic        rx_stb = 1'b0;
    logic [7:0]  data_tx;
    logic        loaded_stb = 1'b0;
    logic        err_stb = 1'b0;
    logic [31:0] ro_in = 32'h01020304;
    logic [31:0] reg_out;
    logic        reg_wr_stb;
    logic [7:0]  reg_wr_idx;
    logic [1:0]  debug_state;

    int total = 0;
    int bad   = 0;

    i2c_register_bank dut (
        .clk                    (clk),
        .rst                    (rst),
        .i2c_addr_rw            (addr_rw),
        .i2c_addr_rw_valid_stb  (addr_stb),
        .i2c_data_rx            (data_rx),
        .i2c_data_rx_valid_stb  (rx_stb),
        .i2c_data_tx            (data_tx),
        .i2c_data_tx_loaded_stb (loaded_stb),
        .i2c_error_stb          (err_stb),
        .ro_in                  (ro_in),
        .reg_out                (reg_out),
        .reg_wr_stb             (reg_wr_stb),
        .reg_wr_idx             (reg_wr_idx),
        .debug_state            (debug_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic addr(input logic [7:0] b);
        @(negedge clk);
        addr_rw = b; addr_stb = 1'b1;
        @(negedge clk);
        addr_stb = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        @(negedge clk);
        data_rx = b; rx_stb = 1'b1;
        @(negedge clk);
        rx_stb = 1'b0;
    endtask

    task automatic loaded();
        @(negedge clk);
        loaded_stb = 1'b1;
        @(negedge clk);
        loaded_stb = 1'b0;
    endtask

    task automatic error();
        @(negedge clk);
        err_stb = 1'b1;
        @(negedge clk);
        err_stb = 1'b0;
    endtask

    initial begin
        logic [7:0] ro_exp [4];
        ro_exp[0] = 8'h04; ro_exp[1] = 8'h03; ro_exp[2] = 8'h02; ro_exp[3] = 8'h01;

        tick();
        check("rst_state", 32'(debug_state), 32'd0);
        check("rst_tx", 32'(data_tx), 32'h00);
        check("rst_regs", reg_out, 32'h0);
        check("rst_wr_stb", 32'(reg_wr_stb), 32'd0);
        check("rst_wr_idx", 32'(reg_wr_idx), 32'd0);
        rst = 1'b0;

        // plain write: ptr 1, then two data bytes
        addr(8'h84);
        check("w_state_wptr", 32'(debug_state), 32'd1);
        rx(8'h01);
        check("w_state_wdata", 32'(debug_state), 32'd2);
        check("w_ptr_no_stb", 32'(reg_wr_stb), 32'd0);
        rx(8'hAA);
        check("w1_stb", 32'(reg_wr_stb), 32'd1);
        check("w1_idx", 32'(reg_wr_idx), 32'd1);
        check("w1_reg", reg_out, 32'h0000AA00);
        rx(8'h55);
        check("w2_stb", 32'(reg_wr_stb), 32'd1);
        check("w2_idx", 32'(reg_wr_idx), 32'd2);
        check("w2_reg", reg_out, 32'h0055AA00);

        // wrap across read-only space
        addr(8'h84);
        rx(8'h03);
        rx(8'h11);
        check("wr3_stb", 32'(reg_wr_stb), 32'd1);
        check("wr3_idx", 32'(reg_wr_idx), 32'd3);
        for (int i = 0; i < 4; i++) begin
            rx(8'h22 + 8'(i) * 8'h11);
            check("ro_drop_stb", 32'(reg_wr_stb), 32'd0);
        end
        rx(8'h66);
        check("wrap_stb", 32'(reg_wr_stb), 32'd1);
        check("wrap_idx", 32'(reg_wr_idx), 32'd0);
        check("wrap_regs", reg_out, 32'h1155AA66);
        tick();
        check("wrap_ptr1_tx", 32'(data_tx), 32'hAA);

        // coherent read of RO snapshot
        addr(8'h84);
        rx(8'h04);
        addr(8'h85);
        check("rd_state", 32'(debug_state), 32'd3);
        ro_in = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_snap_tx", 32'(data_tx), 32'(ro_exp[i]));
            loaded();
        end

        // unmapped pointer
        addr(8'h84);
        rx(8'h20);
        addr(8'h85);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("unm_tx", 32'(data_tx), 32'hFF);
            loaded();
        end
        tick();
        check("unm_hold_tx", 32'(data_tx), 32'hFF);
        addr(8'h84);
        rx(8'h20);
        rx(8'h99);
        check("unm_wr_stb", 32'(reg_wr_stb), 32'd0);
        check("unm_regs", reg_out, 32'h1155AA66);

        // abort, then repeated start
        addr(8'h84);
        rx(8'h02);
        error();
        check("err_state", 32'(debug_state), 32'd0);
        rx(8'h77);
        check("err_rx_state", 32'(debug_state), 32'd0);
        check("err_rx_stb", 32'(reg_wr_stb), 32'd0);
        check("err_regs", reg_out, 32'h1155AA66);
        tick();
        check("err_ptr2_tx", 32'(data_tx), 32'h55);
        addr(8'h84);
        check("restart_state", 32'(debug_state), 32'd1);
        rx(8'h00);
        rx(8'h5A);
        check("restart_idx", 32'(reg_wr_idx), 32'd0);
        check("restart_regs", reg_out, 32'h1155AA5A);

`ifdef I2C_REGBANK_RXCNT_EN
        addr(8'h84); rx(8'hFF); rx(8'h00);
        addr(8'h84); rx(8'h00); rx(8'h10); rx(8'h20); rx(8'h30);
        addr(8'h84); rx(8'hFF);
        addr(8'h85);
        tick();
        check("cnt_read", 32'(data_tx), 32'h03);
        addr(8'h84); rx(8'hFF); rx(8'h00);
        addr(8'h85);
        tick();
        check("cnt_clear", 32'(data_tx), 32'h00);
`else
        addr(8'h84); rx(8'hFF); rx(8'h42);
        check("ff_wr_stb", 32'(reg_wr_stb), 32'd0);
        addr(8'h85);
        tick();
        check("ff_read", 32'(data_tx), 32'hFF);
`endif

        // reset in the same cycle as a data byte commits nothing
        addr(8'h84);
        rx(8'h01);
        @(negedge clk);
        data_rx = 8'h42; rx_stb = 1'b1; rst = 1'b1;
        @(negedge clk);
        rx_stb = 1'b0;
        check("mid_rst_regs", reg_out, 32'h0);
        check("mid_rst_state", 32'(debug_state), 32'd0);
        check("mid_rst_stb", 32'(reg_wr_stb), 32'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
